// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the MMIO UART transmitter: region select,
// write strobe, address, store data and combinational load data.
interface mmio_uart_tx_if;
  logic        sel;
  logic        we;
  logic [15:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (
    output sel,
    output we,
    output address,
    output writeData,
    input  readData
  );

  modport slave (
    input  sel,
    input  we,
    input  address,
    input  writeData,
    output readData
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA queue in a
// small FIFO and are shifted out LSB first at DIVISOR clocks per bit. The
// divisor is captured at each frame start, so reprogramming it never
// disturbs a frame already on the line.
module mmio_uart_tx #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [15:0]     divisor_q, divisor_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [DEPTH];

  logic            wr_s;
  logic [1:0]      reg_idx_s;
  logic            push_req_s;
  logic            push_ok_s;
  logic            pop_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            bit_end_s;
  logic [4:0]      count5_s;
  logic            unused_s;

  assign wr_s         = bus.sel & bus.we;
  assign reg_idx_s    = bus.address[3:2];
  assign push_req_s   = wr_s && (reg_idx_s == 2'd0);
  assign fifo_empty_s = (count_q == CW'(0));
  assign fifo_full_s  = (count_q == CW'(DEPTH));
  assign bit_end_s    = (div_cnt_q == (div_q - 16'd1));
  assign count5_s     = 5'(count_q);
  assign unused_s     = ^{bus.address[15:4], bus.address[1:0], bus.writeData[31:16]};

  assign tx   = tx_q;
  assign busy = busy_q;

  // Serialiser FSM: next state, line level, shift register and bit timing.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    pop_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          div_d     = divisor_q;
          div_cnt_d = 16'd0;
          tx_d      = 1'b0;
          state_d   = S_START;
        end else begin
          tx_d      = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          div_cnt_d = 16'd0;
          bit_cnt_d = 4'd0;
          state_d   = S_DATA;
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          div_cnt_d = 16'd0;
          if (bit_cnt_q == 4'd7) begin
            tx_d      = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = S_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          div_cnt_d = 16'd0;
          if (!fifo_empty_s) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            div_d   = divisor_q;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FIFO bookkeeping, overflow flag and DIVISOR register updates.
  always_comb begin
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    push_ok_s = push_req_s && (!fifo_full_s || pop_s);
    wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d  = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push_req_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else if (wr_s && (reg_idx_s == 2'd1) && bus.writeData[3]) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (wr_s && (reg_idx_s == 2'd2)) begin
      divisor_d = (bus.writeData[15:0] == 16'd0) ? 16'd1 : bus.writeData[15:0];
    end else begin
      divisor_d = divisor_q;
    end
  end

  // Load-data mux; silent unless the MMIO window is selected.
  always_comb begin
    bus.readData = 32'd0;
    if (bus.sel) begin
      case (reg_idx_s)
        2'd1:    bus.readData = {23'd0, count5_s, ovf_q, fifo_empty_s, fifo_full_s, busy_q};
        2'd2:    bus.readData = {16'd0, divisor_q};
        default: bus.readData = 32'd0;
      endcase
    end else begin
      bus.readData = 32'd0;
    end
  end

  // State and control registers with synchronous reset (flushes FIFO, aborts frame).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= 8'd0;
      div_q     <= 16'd0;
      div_cnt_q <= 16'd0;
      bit_cnt_q <= 4'd0;
      divisor_q <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= AW'(0);
      rd_ptr_q  <= AW'(0);
      count_q   <= CW'(0);
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      divisor_q <= divisor_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok_s && !reset) begin
      mem_q[wr_ptr_q] <= bus.writeData[7:0];
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed register accesses checked inline, serial
// frames checked by a monitor against a queue of expected bytes/bit periods.
module tb_mmio_uart_tx;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t exp_q[$];

  mmio_uart_tx_if bus();

  mmio_uart_tx #(.DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] d, input int div);
    exp_t e;
    e.data = d;
    e.div  = div;
    exp_q.push_back(e);
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b1; bus.address = addr; bus.writeData = data;
    @(posedge clk);
    #1;
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.sel = 1'b1; bus.we = 1'b0; bus.address = addr;
    #1;
    check(name, bus.readData, exp);
    bus.sel = 1'b0;
  endtask

  // Counts consecutive post-edge samples with busy=1; bounded.
  task automatic busy_run(output int n);
    n = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) n++;
      else break;
    end
  endtask

  // Monitor: every falling tx edge must be a queued frame with exact bit timing.
  initial begin : monitor
    exp_t       e;
    logic [9:0] fr;
    logic       seen;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: tx went 0 with no byte queued, expected idle tx=1");
        for (int g = 0; g < 70000 && tx === 1'b0; g++) @(negedge clk);
        continue;
      end
      e       = exp_q.pop_front();
      fr      = {1'b1, e.data, 1'b0};
      aborted = 1'b0;
      for (int b = 0; b < 10 && !aborted; b++) begin
        seen = fr[b];
        for (int k = 0; k < e.div && !aborted; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (reset === 1'b1) aborted = 1'b1;
          else if (tx !== fr[b]) seen = tx;
        end
        if (!aborted) check($sformatf("frame_%02h_bit%0d", e.data, b), {31'd0, seen}, {31'd0, fr[b]});
      end
    end
  end

  initial begin : stimulus
    int n;
    int lows;
    reset = 1'b1;
    bus.sel = 1'b0; bus.we = 1'b0; bus.address = 16'h0; bus.writeData = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    bus_read(16'h0004, 32'h0000_0004, "reset_status");
    bus_read(16'h0008, 32'd434, "reset_divisor");
    bus_read(16'h0000, 32'h0, "txdata_reads_zero");
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Single frame, DIV=4, 0x55; busy high for 40 post-edge samples
    bus_write(16'h0008, 32'd4);
    expect_frame(8'h55, 4);
    bus_write(16'h0000, 32'h55);
    busy_run(n);
    check("div4_busy_cycles", n, 32'd40);
    check("div4_tx_idle_after", {31'd0, tx}, 32'd1);

    // Two back-to-back frames at DIV=2
    bus_write(16'h0008, 32'd2);
    expect_frame(8'hA5, 2);
    expect_frame(8'h3C, 2);
    bus_write(16'h0000, 32'hA5);
    bus_write(16'h0000, 32'h3C);
    bus_read(16'h0004, 32'h0000_0011, "b2b_status_count1");
    busy_run(n);
    check("b2b_busy_cycles", n, 32'd39);

    // Overflow at DIV=100, then faster divisor from the second frame on
    bus_write(16'h0008, 32'd100);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) expect_frame(8'h10, 100);
      else if (i < 9) expect_frame(8'(8'h10 + i), 1);
      bus_write(16'h0000, 32'(8'h10 + i));
    end
    bus_read(16'h0004, 32'h0000_008B, "ovf_status_full");
    bus_write(16'h0004, 32'h0000_0008);
    bus_read(16'h0004, 32'h0000_0083, "ovf_cleared");
    bus_write(16'h0008, 32'd1);
    bus_read(16'h0008, 32'd1, "divisor_midframe_write");
    busy_run(n);
    check("ovf_drain_idle", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    check("all_frames_seen", exp_q.size(), 32'd0);

    // sel=0 write ignored and readData forced to 0
    @(negedge clk);
    bus.sel = 1'b0; bus.we = 1'b1; bus.address = 16'h0000; bus.writeData = 32'h77;
    @(posedge clk);
    #1;
    bus.address = 16'h0004;
    #1;
    check("unselected_readdata", bus.readData, 32'h0);
    bus.we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("unselected_tx", {31'd0, tx}, 32'd1);
    bus_read(16'h0004, 32'h0000_0004, "unselected_no_push");
    bus_write(16'h0008, 32'd7);
    bus_read(16'h0008, 32'd7, "divisor_7");
    bus_write(16'h000C, 32'hFFFF_FFFF);
    bus_read(16'h000C, 32'h0, "unmapped_read");
    bus_read(16'h0008, 32'd7, "unmapped_write_ignored");
    bus_write(16'h0008, 32'hFFFF_0000);
    bus_read(16'h0008, 32'd1, "divisor_zero_to_one");

    // Reset mid-frame with bytes queued
    bus_write(16'h0008, 32'd4);
    for (int i = 0; i < 3; i++) begin
      expect_frame(8'(8'hC1 + i), 4);
      bus_write(16'h0000, 32'(8'hC1 + i));
    end
    repeat (11) @(posedge clk);
    #1;
    check("midframe_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    bus_read(16'h0004, 32'h0000_0004, "rst_status_flushed");
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rst_no_frames", lows, 32'd0);
    bus_read(16'h0008, 32'd434, "rst_divisor_default");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It sits directly downstream of the MMU's MMIO region select on the data-memory bus.
- Store-word accesses decoded into the MMIO window write its registers. Loads return status and configuration on the read-data path.
- Written bytes queue in a small FIFO. They are serialised 8N1, LSB first, on a single tx line at a programmable bit period.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two, from 2 to 16.
- DEFAULT_DIV, 16'd434, reset value of DIVISOR, in clocks per bit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  MMIO region select from the MMU; the block responds only when sel=1.
- we  in  1  write enable; qualified by sel.
- address  in  16  physical address; only address[3:2] is decoded, address[1:0] is ignored.
- writeData  in  32  store data.
- readData  out  32  load data; combinational; 0 when sel=0.
- tx  out  1  serial output; idles high.
- busy  out  1  1 while a frame is being shifted.

Behaviour:
- Register map (address[3:2]):
  - 0 = TXDATA. Write pushes writeData[7:0]; a read returns 0.
  - 1 = STATUS, read-only except bit 3. Bit0 = busy, bit1 = fifo full, bit2 = fifo empty, bit3 = overflow (sticky), bits[8:4] = fifo count, other bits 0. Writing 1 to bit 3 clears overflow; all other written bits are ignored.
  - 2 = DIVISOR. Bits[15:0] are read/write; bits[31:16] read 0. Writing 0 stores 1.
  - 3 = unmapped. Reads return 0; writes are ignored.
- Register write: occurs when sel=1 and we=1 at a rising edge. When sel=0, readData=0 and writes are ignored.
- Reset values:
  - tx=1, busy=0, FSM in IDLE.
  - FIFO empty with count 0; overflow=0.
  - DIVISOR=DEFAULT_DIV; shift register and bit counters 0.
- FIFO push:
  - A TXDATA write when count<DEPTH pushes the byte.
  - A TXDATA write when full drops the byte and sets overflow. FIFO contents are unchanged.
- FIFO push and pop in the same cycle: count is unchanged and both operations take effect. This holds even when the FIFO is full, because the pop frees a slot first, so the push is accepted and overflow is not set.
- FSM states: IDLE, START, DATA, STOP. tx is registered. DIV below means the DIVISOR value latched at frame start.
  - IDLE: if the FIFO is non-empty at an edge, pop into the shift register, latch DIVISOR, set tx=0, go to START. A byte captured at edge E therefore produces tx=0 from edge E+1.
  - START: hold tx=0 for DIV clocks, then drive data bit 0 and go to DATA.
  - DATA: 8 bits, LSB first, each held DIV clocks, then tx=1 and go to STOP.
  - STOP: hold tx=1 for DIV clocks. At the final edge, if the FIFO is non-empty, pop, latch DIVISOR, set tx=0 and go to START (back-to-back, no idle gap). Otherwise go to IDLE.
- Frame length: exactly 10*DIV clocks from tx falling to the end of the stop bit.
- DIVISOR writes during a frame take effect at the next frame start, never mid-frame.
- busy = (state != IDLE), registered together with the state.
- Reset asserted mid-frame: on the next edge tx=1, busy=0, and the FIFO is flushed. The partial frame is abandoned and is not resumed.
- Bit counter and divider counter widths: 4 bits and 16 bits; no wrap within a frame for any DIV from 1 to 65535.
- DIV=1 is legal: each bit lasts one clock and a frame is 10 clocks.

Test Plan:
- Reset, then read STATUS (sel=1, address=0x4) -> readData=0x00000004. Read DIVISOR -> 434. tx=1, busy=0.
- Write DIVISOR=4, then TXDATA=0x55 at edge E. tx from edge E+1, 4 clocks per level: 0,1,0,1,0,1,0,1,0,1. busy falls at E+41 and tx stays 1 afterwards.
- With DIV=2, write 0xA5 then 0x3C on consecutive cycles. Two frames of 20 clocks each with no idle between them. The STATUS count reads 1 while the first frame is in flight.
- With DIV=100, write 10 bytes rapidly. The first is popped, 8 fill the FIFO, and the 10th is dropped. STATUS reads full=1, overflow=1, count=8. Write STATUS=0x8 -> overflow=0.
- Write with sel=0 and we=1 to TXDATA -> no push, tx stays 1, readData=0. Read address 0xC -> 0. Write DIVISOR=0 then read -> 1.
- Assert reset at the 15th clock of a DIV=4 frame with 3 bytes queued -> the next edge gives tx=1, busy=0, STATUS=0x4. No further frames appear.
